// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit for the 16-bit single-bus CPU.
// Ports: clk, reset_n (sync, active-low), run, ir[15:0], V/C/N/Z flags,
//   mem_ack in; mem_req, PS[1:0], IL, DX/AX/BX[3:0], MB, FS[3:0], MD,
//   RW, MM, MW, halted, fault, state_o[2:0] out.
module cpu_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic        V,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic [1:0]  PS,
    output logic        IL,
    output logic [3:0]  DX,
    output logic [3:0]  AX,
    output logic [3:0]  BX,
    output logic        MB,
    output logic [3:0]  FS,
    output logic        MD,
    output logic        RW,
    output logic        MM,
    output logic        MW,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t          state, state_d;
    logic [TW-1:0]   cnt, cnt_d;
    logic [3:0]      op;
    logic            timeout;
    logic            unused_flags;

    assign op           = ir[15:12];
    assign unused_flags = V ^ C;
    assign state_o      = state;

    // This waiting cycle is the TIMEOUT-th one; an ack now still wins.
    assign timeout = (cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        mem_req = 1'b0;
        PS      = 2'b00;
        IL      = 1'b0;
        DX      = 4'h0;
        AX      = 4'h0;
        BX      = 4'h0;
        MB      = 1'b0;
        FS      = 4'h0;
        MD      = 1'b0;
        RW      = 1'b0;
        MM      = 1'b0;
        MW      = 1'b0;
        halted  = 1'b0;
        fault   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                MM      = 1'b1;
                if (mem_ack) begin
                    IL      = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                PS      = 2'b01;
                state_d = (op == 4'hF) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                DX      = ir[11:8];
                AX      = ir[7:4];
                BX      = ir[3:0];
                state_d = S_FETCH;
                unique case (op)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: begin
                        FS = op;
                        RW = 1'b1;
                    end
                    4'h9: begin
                        FS = 4'h1;
                        MB = 1'b1;
                        RW = 1'b1;
                    end
                    4'hA, 4'hB: state_d = S_MEM;
                    4'hC: PS = Z ? 2'b10 : 2'b00;
                    4'hD: PS = N ? 2'b10 : 2'b00;
                    4'hE: PS = 2'b11;
                    default: ;
                endcase
            end
            S_MEM: begin
                DX      = ir[11:8];
                AX      = ir[7:4];
                BX      = ir[3:0];
                mem_req = 1'b1;
                // Suppress the store while reset is being applied.
                MW      = (op == 4'hB) && reset_n;
                if (mem_ack) begin
                    if (op == 4'hA) begin
                        MD = 1'b1;
                        RW = 1'b1;
                    end
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    // Counter restarts on every state change and on each ack.
    always_comb begin
        cnt_d = cnt;
        if (state_d != state || mem_ack) cnt_d = '0;
        else if (mem_req) cnt_d = cnt + 1'b1;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer.
// Expected control words come from a per-instruction phase model.
module tb_cpu_sequencer;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset_n, run, V, C, N, Z, mem_ack;
    logic [15:0] ir;
    logic        mem_req, IL, MB, MD, RW, MM, MW, halted, fault;
    logic [1:0]  PS;
    logic [3:0]  DX, AX, BX, FS;
    logic [2:0]  state_o;
    logic [29:0] obs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.TIMEOUT(TO), .TW(4)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .ir(ir),
        .V(V), .C(C), .N(N), .Z(Z), .mem_ack(mem_ack),
        .mem_req(mem_req), .PS(PS), .IL(IL), .DX(DX), .AX(AX),
        .BX(BX), .MB(MB), .FS(FS), .MD(MD), .RW(RW), .MM(MM),
        .MW(MW), .halted(halted), .fault(fault), .state_o(state_o)
    );

    assign obs = {mem_req, PS, IL, DX, AX, BX, MB, FS,
                  MD, RW, MM, MW, halted, fault, state_o};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] cw(
        input logic mr, input logic [1:0] ps, input logic il,
        input logic [3:0] dx, input logic [3:0] ax, input logic [3:0] bx,
        input logic mb, input logic [3:0] fs, input logic md,
        input logic rw, input logic mm, input logic mw,
        input logic h, input logic f, input logic [2:0] st);
        return {mr, ps, il, dx, ax, bx, mb, fs, md, rw, mm, mw, h, f, st};
    endfunction

    task automatic tick(input string tag, input logic [29:0] e);
        #4;
        check(tag, {2'b00, obs}, {2'b00, e});
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_in();
        run     = 1'($urandom);
        mem_ack = 1'($urandom);
        V = 1'($urandom); C = 1'($urandom);
        N = 1'($urandom); Z = 1'($urandom);
    endtask

    task automatic start();
        reset_n = 1'b0;
        rnd_in();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run = 1'b0;
        mem_ack = 1'b0;
        tick("idle", '0);
        run = 1'b1;
        tick("idle_run", '0);
    endtask

    function automatic logic [29:0] exec_exp(input logic [15:0] i,
                                             input logic z, input logic n);
        logic [3:0] o;
        logic [1:0] ps;
        logic [3:0] fs;
        logic       rw, mb;
        o = i[15:12];
        ps = 2'b00; fs = 4'h0; rw = 1'b0; mb = 1'b0;
        if (o >= 4'h1 && o <= 4'h8) begin
            fs = o; rw = 1'b1;
        end else if (o == 4'h9) begin
            fs = 4'h1; rw = 1'b1; mb = 1'b1;
        end else if (o == 4'hC) begin
            ps = z ? 2'b10 : 2'b00;
        end else if (o == 4'hD) begin
            ps = n ? 2'b10 : 2'b00;
        end else if (o == 4'hE) begin
            ps = 2'b11;
        end
        return cw(0, ps, 0, i[11:8], i[7:4], i[3:0], mb, fs,
                  0, rw, 0, 0, 0, 0, 3'd3);
    endfunction

    // delay = number of cycles without ack before the ack cycle
    task automatic access(input int delay, input bit is_fetch,
                          input logic [15:0] i, output bit flt);
        logic ld, st;
        ld = !is_fetch && i[15:12] == 4'hA;
        st = !is_fetch && i[15:12] == 4'hB;
        flt = 1'b1;
        for (int d = 0; d < TO; d++) begin
            rnd_in();
            mem_ack = (d == delay);
            if (is_fetch)
                tick("fetch", cw(1, 0, mem_ack, 0, 0, 0, 0, 0,
                                 0, 0, 1, 0, 0, 0, 3'd1));
            else
                tick("mem", cw(1, 0, 0, i[11:8], i[7:4], i[3:0], 0, 0,
                               ld & mem_ack, ld & mem_ack, 0, st,
                               0, 0, 3'd4));
            if (d == delay) begin
                flt = 1'b0;
                break;
            end
        end
    endtask

    task automatic fault_chk();
        repeat (3) begin
            rnd_in();
            tick("fault", cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                             0, 0, 0, 1, 3'd6));
        end
    endtask

    task automatic do_instr(input logic [15:0] i, input int fd,
                            input int md, input int zf, input int nf,
                            output bit dead);
        bit flt;
        dead = 1'b1;
        ir = i;
        access(fd, 1'b1, i, flt);
        if (flt) begin
            fault_chk();
            return;
        end
        rnd_in();
        tick("decode", cw(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 3'd2));
        if (i[15:12] == 4'hF) begin
            repeat (4) begin
                rnd_in();
                tick("halt", cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                0, 0, 1, 0, 3'd5));
            end
            return;
        end
        rnd_in();
        if (zf >= 0) Z = 1'(zf);
        if (nf >= 0) N = 1'(nf);
        tick("exec", exec_exp(i, Z, N));
        if (i[15:12] == 4'hA || i[15:12] == 4'hB) begin
            access(md, 1'b0, i, flt);
            if (flt) begin
                fault_chk();
                return;
            end
        end
        dead = 1'b0;
    endtask

    function automatic int rnd_delay();
        if ($urandom_range(0, 9) == 0) return $urandom_range(13, 16);
        return $urandom_range(0, 3);
    endfunction

    initial begin
        bit dead;
        reset_n = 1'b0; run = 1'b0; ir = '0; mem_ack = 1'b0;
        V = 0; C = 0; N = 0; Z = 0;
        @(posedge clk);
        #1;
        start();
        do_instr(16'h1123, 1, 0, -1, -1, dead);
        do_instr(16'hA450, 0, 3, -1, -1, dead);
        do_instr(16'hB0A7, 0, 2, -1, -1, dead);
        do_instr(16'hC003, 0, 0, 1, -1, dead);
        do_instr(16'hC003, 0, 0, 0, -1, dead);
        do_instr(16'hD012, 0, 0, -1, 1, dead);
        do_instr(16'hE050, 0, 0, -1, -1, dead);
        do_instr(16'h9A0F, 0, 0, -1, -1, dead);
        do_instr(16'hA123, 0, 14, -1, -1, dead);
        do_instr(16'h0000, 15, 0, -1, -1, dead);
        check("timeout_fault", {31'd0, dead}, 32'd1);
        start();
        do_instr(16'h1123, 14, 0, -1, -1, dead);
        check("ack_at_limit", {31'd0, dead}, 32'd0);
        do_instr(16'hB321, 0, 15, -1, -1, dead);
        check("mem_timeout", {31'd0, dead}, 32'd1);
        start();
        do_instr(16'hF000, 0, 0, -1, -1, dead);
        start();
        // reset in the middle of a store
        do_instr(16'hB0A7, 0, 0, -1, -1, dead);
        ir = 16'hB0A7;
        access(0, 1'b1, ir, dead);
        rnd_in();
        tick("decode", cw(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 3'd2));
        rnd_in();
        tick("exec_st", exec_exp(ir, Z, N));
        rnd_in();
        mem_ack = 1'b0;
        tick("mem_st", cw(1, 0, 0, 4'h0, 4'hA, 4'h7, 0, 0, 0, 0,
                          0, 1, 0, 0, 3'd4));
        reset_n = 1'b0;
        mem_ack = 1'b0;
        #4;
        check("mw_in_reset", {31'd0, MW}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run = 1'b0;
        tick("idle_after_rst", '0);
        run = 1'b1;
        tick("idle_run", '0);
        for (int k = 0; k < 150; k++) begin
            do_instr(16'($urandom), rnd_delay(), rnd_delay(),
                     -1, -1, dead);
            if (dead) start();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control unit for the 16-bit single-bus CPU.
- Sequences fetch, decode, execute and memory phases.
- Drives the control word for the register file, function unit, bus muxes and PC. Handshakes with memory via mem_req/mem_ack, with a bounded wait.
- Sits between the instruction register and the datapath; the IR is loaded externally on IL.

Parameters:
- TIMEOUT, 15: maximum cycles mem_req may wait for mem_ack before fault.
- TW, 4: width of the wait counter; TIMEOUT must be less than 2^TW.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- run  in  1  leave IDLE and begin fetching
- ir  in  16  instruction register: opcode[15:12], DR[11:8], SA[7:4], SB[3:0]
- V, C, N, Z  in  1 each  registered status flags from the function unit
- mem_ack  in  1  memory transfer complete this cycle
- mem_req  out  1  memory access request
- PS  out  2  PC control: 00 hold, 01 increment, 10 branch (PC+sext{DR,SB}), 11 jump (R[SA])
- IL  out  1  instruction load strobe
- DX, AX, BX  out  4 each  destination, A-select and B-select register addresses
- MB  out  1  B-mux: 1 = zero-filled constant from SB
- FS  out  4  function select
- MD  out  1  D-mux: 1 = memory data
- RW  out  1  register write
- MM  out  1  address mux: 1 = PC, 0 = A bus
- MW  out  1  memory write
- halted  out  1  in HALT state
- fault  out  1  in FAULT state
- state_o  out  3  current state encoding, for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=5, FAULT=6.
- Registered: state and wait counter only. All other outputs are combinational from state, ir, flags and mem_ack.
- Default output value is 0 unless listed for the state.
- Reset (reset_n low at a clock edge): state becomes IDLE, wait counter clears. All outputs are then 0, state_o=0. Reset overrides any state, including mid-MEM; no memory write may be issued in the reset cycle.
- IDLE: all outputs 0. run=1 -> FETCH.
- FETCH: mem_req=1, MM=1.
  - If mem_ack=1: IL=1 that cycle, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: PS=01 for exactly one cycle. Next state is EXEC, or HALT if opcode=F.
- EXEC, by opcode (DX=DR, AX=SA, BX=SB pass through in EXEC and MEM):
  - 0 NOP: no writes.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 SHL, 8 SHR: FS=opcode, RW=1.
  - 9 ADI: FS=0001, MB=1, RW=1.
  - A LD and B ST: FS=0000, next state MEM.
  - C BRZ: PS=10 if Z=1, else 00.
  - D BRN: PS=10 if N=1, else 00.
  - E JMP: PS=11.
  - All except A/B return to FETCH.
- MEM: mem_req=1, MM=0, FS=0000.
  - ST: MW=1 throughout.
  - LD: on the mem_ack cycle, MD=1 and RW=1.
  - mem_ack -> FETCH.
- Wait counter: clears on state entry to FETCH/MEM and on mem_ack; increments each cycle mem_req=1 without mem_ack. If mem_ack has not arrived when the counter reaches TIMEOUT -> FAULT.
  - mem_ack arriving in the same cycle the counter reaches TIMEOUT is accepted; no fault.
- HALT: halted=1, all control 0; exit only by reset. FAULT: fault=1, all control 0; exit only by reset.
- run is ignored outside IDLE.
- Flags are sampled only in the EXEC cycle of a branch.
- PS and RW are never asserted in the same cycle except where listed above.

Test Plan:
- Reset then run=1, ir=0x1123, mem_ack high on the 2nd FETCH cycle -> IL=1 in that cycle only; DECODE PS=01; EXEC FS=0001, RW=1, DX=1, AX=2, BX=3; then FETCH. Total 5 cycles from run.
- ir=0xA450 (LD), mem_ack 3 cycles late in MEM -> MM=0, mem_req held 4 cycles; MD=RW=1 only on the ack cycle; MW never 1.
- ir=0xB0A7 (ST) -> MW=1 and mem_req=1 for every MEM cycle until ack; RW=0 throughout.
- BRZ ir=0xC003 with Z=1 -> PS=10 in EXEC; repeat with Z=0 -> PS=00; ir=0xE050 -> PS=11.
- mem_ack withheld in FETCH with TIMEOUT=15 -> FAULT after 15 waiting cycles, fault=1, mem_req=0. Repeat with ack on exactly the 15th cycle -> no fault.
- ir=0xF000 -> halted=1 after DECODE and stays set while run toggles. reset_n low during MEM of a ST -> next state IDLE, MW=0 in the cycle after the reset edge.
